// File: rtl/fetch_vector_control.sv
// fetch_vector_control
//   Sequences vector fetches for reset and for NUM_INT fixed-priority interrupt
//   lines (line 0 highest). While a lookup is in progress the fetch stage is
//   held (extend) and the vector source is presented on fetchSrc. A lookup
//   advances only on cycles where instruction memory accepts it (mem_ready) and
//   completes after LOOK_CYCLES such cycles. At that point the serviced line is
//   acked, and the next pending line (if any) is started back-to-back.
//
//   Optional build macro: FETCH_VEC_MASK_EN adds the int_mask port. Masked
//   lines are ignored for arbitration. Without the macro, all lines are enabled.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset; starts a reset-vector lookup
//   int_req    level interrupt requests, held until acked
//   mem_ready  memory accepted this lookup cycle
//   int_mask   per-line enable, 1=enabled (FETCH_VEC_MASK_EN only)
//   extend     hold fetch stage during a lookup
//   fetch      vector-fetch strobe to PC-select
//   fetchSrc   0=reset vector, k+1=interrupt line k
//   int_ack    one-hot, one-cycle acknowledge of the serviced line
//   busy       high while a lookup is in progress
module fetch_vector_control #(
  parameter int NUM_INT     = 3,
  parameter int LOOK_CYCLES = 1,
  localparam int SRC_W      = $clog2(NUM_INT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] int_req,
  input  logic               mem_ready,
`ifdef FETCH_VEC_MASK_EN
  input  logic [NUM_INT-1:0] int_mask,
`endif
  output logic               extend,
  output logic               fetch,
  output logic [SRC_W-1:0]   fetchSrc,
  output logic [NUM_INT-1:0] int_ack,
  output logic               busy
);

  typedef enum logic {NORM = 1'b0, LOOK = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(LOOK_CYCLES - 1);

  state_t             state, state_nxt;
  logic [SRC_W-1:0]   src, src_nxt;
  logic [7:0]         cnt, cnt_nxt;
  logic               is_int, is_int_nxt;
  logic [NUM_INT-1:0] eff;
  logic [NUM_INT-1:0] remain;
  logic               done;

  // Lowest set index wins; result is the fetchSrc encoding (index+1), 0 if none.
  function automatic logic [SRC_W-1:0] pick(input logic [NUM_INT-1:0] v);
    logic [SRC_W-1:0] w;
    w = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (v[i]) w = SRC_W'(i + 1);
    end
    return w;
  endfunction

`ifdef FETCH_VEC_MASK_EN
  assign eff = int_req & int_mask;
`else
  assign eff = int_req;
`endif

  assign done = (state == LOOK) && mem_ready && (cnt == CNT_LAST);

  // The ack decodes from registered src so a line masked or dropped during
  // its own lookup is still acked when that lookup completes.
  always_comb begin
    int_ack = '0;
    if (done && is_int) begin
      for (int i = 0; i < NUM_INT; i++) begin
        if (src == SRC_W'(i + 1)) int_ack[i] = 1'b1;
      end
    end
  end

  // Requests still waiting once the line being acked is removed.
  assign remain = eff & ~int_ack;

  always_comb begin
    state_nxt  = state;
    src_nxt    = src;
    cnt_nxt    = cnt;
    is_int_nxt = is_int;
    case (state)
      NORM: begin
        if (eff != '0) begin
          state_nxt  = LOOK;
          src_nxt    = pick(eff);
          cnt_nxt    = '0;
          is_int_nxt = 1'b1;
        end
      end
      LOOK: begin
        if (mem_ready) begin
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (remain != '0) begin
              state_nxt  = LOOK;
              src_nxt    = pick(remain);
              is_int_nxt = 1'b1;
            end else begin
              state_nxt  = NORM;
              src_nxt    = '0;
              is_int_nxt = 1'b0;
            end
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      default: state_nxt = NORM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOOK;
      src    <= '0;
      cnt    <= '0;
      is_int <= 1'b0;
    end else begin
      state  <= state_nxt;
      src    <= src_nxt;
      cnt    <= cnt_nxt;
      is_int <= is_int_nxt;
    end
  end

  assign extend   = (state == LOOK);
  assign fetch    = (state == LOOK);
  assign busy     = (state == LOOK);
  assign fetchSrc = (state == LOOK) ? src : '0;

endmodule

// File: tb/tb_fetch_vector_control.sv
module tb_fetch_vector_control;

  localparam int N     = 3;
  localparam int LC    = 2;
  localparam int SRC_W = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     int_req;
  logic             mem_ready;
  logic [N-1:0]     int_mask;
  logic             extend, fetch, busy;
  logic [SRC_W-1:0] fetchSrc;
  logic [N-1:0]     int_ack;

  always #5 clk = ~clk;

  fetch_vector_control #(.NUM_INT(N), .LOOK_CYCLES(LC)) dut (
    .clk      (clk),
    .rst      (rst),
    .int_req  (int_req),
    .mem_ready(mem_ready),
`ifdef FETCH_VEC_MASK_EN
    .int_mask (int_mask),
`endif
    .extend   (extend),
    .fetch    (fetch),
    .fetchSrc (fetchSrc),
    .int_ack  (int_ack),
    .busy     (busy)
  );

  typedef struct packed {
    logic             look;
    logic [SRC_W-1:0] src;
    logic [N-1:0]     ack;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: a lookup is "which vector, how many accepted cycles left".
  bit           m_valid = 0;
  bit           m_look  = 0;
  int           m_src   = 0;
  int           m_left  = 0;
  logic [N-1:0] p_eff   = '0;
  logic [N-1:0] p_ack   = '0;
  logic         p_mr    = 1'b0;
  logic         p_rst   = 1'b0;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [N-1:0] enabled(input logic [N-1:0] r, input logic [N-1:0] m);
`ifdef FETCH_VEC_MASK_EN
    return r & m;
`else
    return r;
`endif
  endfunction

  // Advance the model by the edge that just sampled the previous cycle's inputs.
  task automatic model_edge();
    logic [N-1:0] pend;
    if (p_rst) begin
      m_valid = 1; m_look = 1; m_src = 0; m_left = LC;
    end else if (m_valid) begin
      if (m_look) begin
        if (p_mr) begin
          m_left--;
          if (m_left == 0) begin
            pend = p_eff & ~p_ack;
            if (pend != '0) begin
              m_src = lowest(pend); m_left = LC;
            end else begin
              m_look = 0; m_src = 0;
            end
          end
        end
      end else if (p_eff != '0) begin
        m_look = 1; m_src = lowest(p_eff); m_left = LC;
      end
    end
  endtask

  // One clock cycle: requesters release acked lines, raise/drop extra lines.
  task automatic step(input logic [N-1:0] raise, input logic [N-1:0] drop,
                      input logic mr, input logic r);
    exp_t e;
    bit   completing;
    @(posedge clk);
    model_edge();
    #1;
    completing = m_valid && m_look && mr && (m_left == 1) && (m_src != 0);
    if (completing) r = 1'b0;
    int_req   = ((int_req & ~p_ack) | raise) & ~drop;
    mem_ready = mr;
    rst       = r;
    e.look = m_look;
    e.src  = m_look ? SRC_W'(m_src) : '0;
    e.ack  = completing ? N'(1 << (m_src - 1)) : '0;
    if (m_valid) q.push_back(e);
    p_eff = enabled(int_req, int_mask);
    p_ack = e.ack;
    p_mr  = mr;
    p_rst = r;
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: DUT presents outputs every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("extend",   int'(extend),   int'(e.look));
        chk("fetch",    int'(fetch),    int'(e.look));
        chk("busy",     int'(busy),     int'(e.look));
        chk("fetchSrc", int'(fetchSrc), int'(e.src));
        chk("int_ack",  int'(int_ack),  int'(e.ack));
      end
    end
  end

  initial begin
    int_req = '0; mem_ready = 1'b1; rst = 1'b1; int_mask = '1;

    // reset lookup runs LC cycles then NORM
    step('0, '0, 1'b1, 1'b1);
    repeat (4) step('0, '0, 1'b1, 1'b0);

    // line 1 then back-to-back line 2
    step(3'b110, '0, 1'b1, 1'b0);
    repeat (7) step('0, '0, 1'b1, 1'b0);

    // stalled lookup: mem_ready 1,0,0,1
    step(3'b001, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    repeat (2) step('0, '0, 1'b1, 1'b0);

    // reset in first cycle of a line-0 lookup; line 0 then withdraws
    step(3'b001, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b1);
    step('0, 3'b001, 1'b1, 1'b0);
    repeat (4) step('0, '0, 1'b1, 1'b0);

    // line 0 rises while line 2 is mid-lookup
    step(3'b100, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step(3'b001, '0, 1'b1, 1'b0);
    repeat (5) step('0, '0, 1'b1, 1'b0);

`ifdef FETCH_VEC_MASK_EN
    int_mask = 3'b110;
    step(3'b001, '0, 1'b1, 1'b0);
    repeat (3) step('0, '0, 1'b1, 1'b0);
    int_mask = 3'b111;
    repeat (5) step('0, '0, 1'b1, 1'b0);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] rs, dr;
      rs = N'($urandom) & N'($urandom);
      dr = ($urandom_range(0, 31) == 0) ? N'($urandom) : '0;
`ifdef FETCH_VEC_MASK_EN
      if ($urandom_range(0, 15) == 0) int_mask = N'($urandom);
`endif
      step(rs, dr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
    end

    // drain scoreboard with a bounded wait
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_vector_control.md
Name: fetch_vector_control

Overview:
Parametrised successor to the single-interrupt fetch controller. Sequences vector fetches for reset and for NUM_INT prioritised interrupt sources. Holds the fetch stage in a multi-cycle lookup state that is stall-aware via mem_ready. Acknowledges the serviced source and sits between the interrupt lines and the fetch/PC-select logic.

Parameters:
NUM_INT, 3, number of interrupt request lines (>=1)
LOOK_CYCLES, 1, number of mem_ready-qualified cycles a vector lookup occupies (>=1, <=255)
SRC_W, localparam = $clog2(NUM_INT+1), width of fetchSrc; default gives 2

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
int_req  input  NUM_INT  level interrupt requests; requester holds until its int_ack
mem_ready  input  1  instruction memory accepted this lookup cycle
int_mask  input  NUM_INT  per-line enable, 1=enabled (only with FETCH_VEC_MASK_EN)
extend  output  1  hold/extend fetch stage while a vector lookup is in progress
fetch  output  1  vector-fetch strobe to the PC-select logic
fetchSrc  output  SRC_W  vector source: 0=reset, k+1=interrupt line k
int_ack  output  NUM_INT  one-hot, one-cycle acknowledge of the serviced line
busy  output  1  high in LOOK

Behaviour:
- States: NORM, LOOK. Registers: state, src (SRC_W), cnt (8b), is_int (1b).
- Reset: rst=1 sampled at posedge sets state=LOOK, src=0, cnt=0, is_int=0. Resulting outputs: extend=1, fetch=1, fetchSrc=0, busy=1, int_ack=0. Reset mid-LOOK aborts the lookup in progress and restarts a reset lookup. No ack is issued for the aborted lookup.
- Outputs are decoded from registered state only. No combinational path from int_req to outputs.
- NORM outputs: extend=0, fetch=0, fetchSrc=0, busy=0, int_ack=0.
- LOOK outputs: extend=1, fetch=1, busy=1, fetchSrc=src.
- Effective request: eff = int_req (& int_mask with macro).
- NORM -> LOOK: taken when eff != 0. Winner k is the lowest set index (fixed priority, index 0 highest). Load src=k+1, is_int=1, cnt=0. Transition is visible the cycle after the request is sampled, so latency from request to fetch=1 is 1 cycle.
- LOOK counting: cnt increments only on cycles with mem_ready=1. mem_ready=0 holds all state.
- LOOK completion: occurs on a cycle with mem_ready=1 and cnt==LOOK_CYCLES-1. In that same cycle:
  - int_ack[src-1]=1 if is_int; no ack for a reset lookup.
  - Next state is chosen from eff with the acked bit cleared. If any bit remains, go straight to LOOK for the new winner (back-to-back, no NORM bubble). Otherwise go to NORM.
- Requests that arrive or change during LOOK do not preempt the current lookup. They are arbitrated only at completion or in NORM.
- A request dropped before its ack is simply not serviced; no error is raised.
- int_ack is combinational from registered state and mem_ready, and is high for exactly one cycle per completed interrupt lookup.
- LOOK_CYCLES=1: each lookup lasts exactly 1 cycle when mem_ready=1.

Optional Feature:
- Macro: FETCH_VEC_MASK_EN.
- Defined: int_mask port exists; masked lines are ignored for arbitration and for back-to-back selection. A line masked while its lookup is in progress still completes and is acked.
- Undefined: port absent; all lines are treated as enabled.

Test Plan:
- Reset release, NUM_INT=3, LOOK_CYCLES=2, mem_ready=1: fetch=1 with fetchSrc=0 for 2 cycles, then NORM with extend=0; int_ack stays 0 throughout.
- In NORM, int_req=3'b110: next cycle fetchSrc=2 (line 1). At completion int_ack=3'b010. Holding req[2] gives back-to-back LOOK with fetchSrc=3 and no NORM cycle, then int_ack=3'b100.
- LOOK_CYCLES=2 with mem_ready pattern 1,0,0,1: LOOK lasts 4 cycles and int_ack pulses on the 4th.
- rst asserted in the 1st cycle of an interrupt LOOK (src=1): next cycle fetchSrc=0, no int_ack is ever issued for line 0, and the reset lookup runs its full length.
- int_req[0] rises while line 2 is mid-lookup: line 2 completes undisturbed, then line 0 is serviced back-to-back with fetchSrc=1.
- With FETCH_VEC_MASK_EN, int_mask=3'b110 and int_req=3'b001: stays in NORM. Setting mask bit 0 gives LOOK with fetchSrc=1 the next cycle.
